// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one ALU between two requesters, optional ALU_ARB_PERF_EN counters
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_A,
    input  logic [DATA_W-1:0] req0_B,
    input  logic [3:0]        req0_sel,
    input  logic [TAG_W-1:0]  req0_rd,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_A,
    input  logic [DATA_W-1:0] req1_B,
    input  logic [3:0]        req1_sel,
    input  logic [TAG_W-1:0]  req1_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [TAG_W-1:0]  rsp_rd
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam int SH_W = $clog2(DATA_W);

    logic              last_grant;
    logic              can_accept;
    logic              gnt_id;
    logic              fire;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic [SH_W-1:0]   shamt;

    assign can_accept = !rsp_valid || rsp_ready;

    // With both valid the port that did not win last time goes next.
    always_comb begin
        gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    assign fire       = can_accept && (req0_valid || req1_valid) && !rst;
    assign req0_ready = fire && !gnt_id;
    assign req1_ready = fire && gnt_id;

    assign alu_a   = gnt_id ? req1_A   : req0_A;
    assign alu_b   = gnt_id ? req1_B   : req0_B;
    assign alu_sel = gnt_id ? req1_sel : req0_sel;
    assign shamt   = alu_b[SH_W-1:0];

    always_comb begin
        alu_out = '0;
        case (alu_sel)
            OP_ADD:  alu_out = alu_a + alu_b;
            OP_SUB:  alu_out = alu_a - alu_b;
            OP_AND:  alu_out = alu_a & alu_b;
            OP_OR:   alu_out = alu_a | alu_b;
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_SLL:  alu_out = alu_a << shamt;
            OP_SRL:  alu_out = alu_a >> shamt;
            OP_SRA:  alu_out = $signed(alu_a) >>> shamt;
            OP_SLT:  alu_out = {{(DATA_W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU: alu_out = {{(DATA_W-1){1'b0}}, alu_a < alu_b};
            default: alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_rd     <= '0;
            last_grant <= 1'b1;
        end else if (fire) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_id;
            rsp_result <= alu_out;
            rsp_zero   <= alu_zero;
            rsp_rd     <= gnt_id ? req1_rd : req0_rd;
            last_grant <= gnt_id;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (req0_ready) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (req1_ready) grant_cnt1 <= grant_cnt1 + 32'd1;
            if (rsp_valid && !rsp_ready && (req0_valid || req1_valid))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed bench with scoreboard model for alu_share_arbiter
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
    localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [3:0]        req0_sel, req1_sel;
    logic [TAG_W-1:0]  req0_rd, req1_rd;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [DATA_W-1:0] rsp_result;
    logic [TAG_W-1:0]  rsp_rd;
    logic [31:0]       grant_cnt0, grant_cnt1, stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req0_sel(req0_sel), .req0_rd(req0_rd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .req1_sel(req1_sel), .req1_rd(req1_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_rd(rsp_rd)
`ifdef ALU_ARB_PERF_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
`endif
    );

`ifndef ALU_ARB_PERF_EN
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
    assign stall_cnt  = '0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] alu_ref(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        int sh;
        sh = int'(b % DATA_W);
        case (op)
            ADD:  return a + b;
            SUB:  return a - b;
            AND_: return a & b;
            OR_:  return a | b;
            XOR_: return a ^ b;
            SLL:  return a << sh;
            SRL:  return a >> sh;
            SRA:  return DATA_W'($signed(a) >>> sh);
            SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
            SLTU: return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Scoreboard: what the slot must hold and who must win, updated once per cycle at negedge.
    bit                m_full = 0;
    int                m_last = 1;
    int                m_id = 0;
    logic [DATA_W-1:0] m_res = '0;
    logic [TAG_W-1:0]  m_rd = '0;
    longint            m_gcnt0 = 0, m_gcnt1 = 0, m_stall = 0;
    int                grant_log[$];
    int                rd_log[$];

    always @(negedge clk) begin
        int  g;
        bit  any;
        any = (!m_full || rsp_ready) && (req0_valid || req1_valid) && !rst;
        g = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
        chk("model_req0_ready", req0_ready, any && g == 0);
        chk("model_req1_ready", req1_ready, any && g == 1);
        chk("model_rsp_valid", rsp_valid, m_full);
        if (m_full) begin
            chk("model_rsp_id", rsp_id, m_id);
            chk("model_rsp_result", rsp_result, m_res);
            chk("model_rsp_zero", rsp_zero, m_res == 0);
            chk("model_rsp_rd", rsp_rd, m_rd);
        end
`ifdef ALU_ARB_PERF_EN
        chk("model_grant_cnt0", grant_cnt0, m_gcnt0 % 64'h1_0000_0000);
        chk("model_grant_cnt1", grant_cnt1, m_gcnt1 % 64'h1_0000_0000);
        chk("model_stall_cnt", stall_cnt, m_stall % 64'h1_0000_0000);
`endif
        if (rst) begin
            m_full = 0; m_last = 1; m_gcnt0 = 0; m_gcnt1 = 0; m_stall = 0;
        end else begin
            if (m_full && !rsp_ready && (req0_valid || req1_valid)) m_stall++;
            if (any) begin
                m_full = 1; m_last = g; m_id = g;
                m_res = (g == 1) ? alu_ref(req1_sel, req1_A, req1_B) : alu_ref(req0_sel, req0_A, req0_B);
                m_rd  = (g == 1) ? req1_rd : req0_rd;
                grant_log.push_back(g);
                rd_log.push_back(int'(m_rd));
                if (g == 1) m_gcnt1++; else m_gcnt0++;
            end else if (rsp_ready) begin
                m_full = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};
        rst = 1; rsp_ready = 1;
        req0_valid = 1; req0_A = 5;   req0_B = 7;  req0_sel = ADD; req0_rd = 3;
        req1_valid = 1; req1_A = 100; req1_B = 20; req1_sel = SUB; req1_rd = 9;

        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_rd", rsp_rd, 0);

        step(1);
        rst = 0;
        grant_log.delete(); rd_log.delete();
        @(negedge clk);
        chk("first_req0_ready", req0_ready, 1);
        chk("first_req1_ready", req1_ready, 0);
        step(1);
        @(negedge clk);
        chk("first_rsp_valid", rsp_valid, 1);
        chk("first_rsp_result", rsp_result, 12);
        chk("first_rsp_id", rsp_id, 0);
        chk("first_rsp_zero", rsp_zero, 0);
        step(3);

        chk("rr_log_size", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            chk("rr_grant_order", grant_log[i], exp_g[i]);
            chk("rr_rd_order", rd_log[i], (exp_g[i] == 0) ? 3 : 9);
        end
        chk("rr_no_bubble", rsp_valid, 1);

        req0_valid = 0;
        req1_A = 32'h1234; req1_B = 32'h1234; req1_sel = SUB; req1_rd = 7;
        step(1);
        req0_valid = 1; req0_A = 32'hF0F0; req0_B = 32'h0FF0; req0_sel = XOR_; req0_rd = 12;
        rsp_ready = 0;
        @(negedge clk);
        chk("sub_rsp_result", rsp_result, 0);
        chk("sub_rsp_zero", rsp_zero, 1);
        chk("sub_rsp_id", rsp_id, 1);
        step(2);
        @(negedge clk);
        chk("stall_req0_ready", req0_ready, 0);
        chk("stall_req1_ready", req1_ready, 0);
        chk("stall_rsp_rd", rsp_rd, 7);
        step(1);
        rsp_ready = 1;
        @(negedge clk);
        chk("drain_req0_ready", req0_ready, 1);
        chk("drain_req1_ready", req1_ready, 0);
        step(1);
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        @(negedge clk);
        chk("drain_rsp_valid", rsp_valid, 1);
        chk("drain_rsp_result", rsp_result, 32'hFF00);
        chk("drain_rsp_rd", rsp_rd, 12);

        step(1);
        rst = 1; req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("midrst_req0_ready", req0_ready, 0);
        chk("midrst_req1_ready", req1_ready, 0);
        step(1);
        rst = 0; req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        step(1);
        @(negedge clk);
        chk("midrst_no_replay", rsp_valid, 0);
        step(1);
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        @(negedge clk);
        chk("midrst_tie_req0", req0_ready, 1);
        chk("midrst_tie_req1", req1_ready, 0);
        step(1);
        req0_valid = 0; req1_valid = 0;

        step(1);
        rst = 1;
        step(1);
        rst = 0; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        req0_A = 32'h8000_0000; req0_B = 4; req0_sel = SRA; req0_rd = 1;
        req1_A = 32'hFFFF_FFFF; req1_B = 1; req1_sel = ADD; req1_rd = 2;
        grant_log.delete(); rd_log.delete();
        step(10);
        rsp_ready = 0;
        step(2);
        req0_valid = 0; req1_valid = 0;
        chk("perf_log_size", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk("perf_alternate", grant_log[i], i % 2);
        @(negedge clk);
        chk("perf_hold_result", rsp_result, 0);
        chk("perf_hold_zero", rsp_zero, 1);
`ifdef ALU_ARB_PERF_EN
        chk("perf_grant_cnt0", grant_cnt0, 5);
        chk("perf_grant_cnt1", grant_cnt1, 5);
        chk("perf_stall_cnt", stall_cnt, 2);
`endif
        step(1);
        rsp_ready = 1;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
